// File: rtl/ps_mcu_uart_pkg.sv
// Shared types and width helpers for the PS <-> MCU UART bridge.
package ps_mcu_uart_pkg;

  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_BAUD_DIV   = 868;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Baud counter only ever holds BAUD_DIV-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned baud_div);
    return $clog2(baud_div);
  endfunction

  // Bit index must hold 0..DATA_W-1.
  function automatic int unsigned idx_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 port list.
// Pushes into a full FIFO and pops from an empty one are ignored, so a push
// while full is lost even if a pop happens in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned N = (DEPTH > 0) ? DEPTH : 1;

  logic [ADDR_DEPTH-1:0] rd_q, wr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [N];
  logic                  is_empty, bypass, do_push, do_pop;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign is_empty = (cnt_q == '0);
  assign bypass   = FALL_THROUGH && is_empty && push_i && pop_i;
  assign full_o   = (cnt_q == (ADDR_DEPTH+1)'(N));
  assign empty_o  = is_empty && !(FALL_THROUGH && push_i);
  assign usage_o  = cnt_q[ADDR_DEPTH-1:0];
  assign do_push  = push_i && !full_o && !bypass;
  assign do_pop   = pop_i && !is_empty;
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_q];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(N); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + ADDR_DEPTH'(1);
      end
      if (do_pop) rd_q <= rd_q + ADDR_DEPTH'(1);
      cnt_q <= cnt_q + (ADDR_DEPTH+1)'(do_push) - (ADDR_DEPTH+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps_mcu_uart_channel.sv
// One bridge channel: TX FIFO + serialiser towards the MCU, synchroniser +
// deserialiser + RX FIFO towards the PS, and sticky error flags.
module ps_mcu_uart_channel
  import ps_mcu_uart_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              uart_tx_o,
  input  logic              uart_rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overflow_o,
  output logic              frame_err_o,
  input  logic              clear_err_i
);

  localparam int unsigned CNT_W  = cnt_width(BAUD_DIV);
  localparam int unsigned IDX_W  = idx_width(DATA_W);
  localparam int unsigned ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic rst_n;
  assign rst_n = ~rst_i;

  // ---------------- TX path ----------------
  logic              tx_full, tx_empty, tx_pop, tx_expire;
  logic [DATA_W-1:0] tx_head;
  logic [ADDR_W-1:0] tx_usage_unused;

  tx_state_e         tx_state_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [IDX_W-1:0]  tx_idx_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              uart_tx_q;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DATA_W),
    .DEPTH        (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_n),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (tx_full),
    .empty_o    (tx_empty),
    .usage_o    (tx_usage_unused),
    .data_i     (tx_data_i),
    .push_i     (tx_valid_i),
    .data_o     (tx_head),
    .pop_i      (tx_pop)
  );

  assign tx_ready_o = ~tx_full;
  assign tx_expire  = (tx_cnt_q == '0);
  // Pop when idle, or at the end of a stop bit so frames chain without a gap.
  assign tx_pop     = ~tx_empty &&
                      ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_expire));
  assign uart_tx_o  = uart_tx_q;

  // TX serialiser; the line register follows the state one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_START: uart_tx_q <= 1'b0;
        TX_DATA:  uart_tx_q <= tx_shift_q[0];
        default:  uart_tx_q <= 1'b1;
      endcase
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_cnt_q   <= CNT_BIT;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_expire) begin
            tx_cnt_q   <= CNT_BIT;
            tx_idx_q   <= '0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_expire) begin
            tx_cnt_q   <= CNT_BIT;
            tx_shift_q <= tx_shift_q >> 1;
            if (tx_idx_q == IDX_LAST) tx_state_q <= TX_STOP;
            else                      tx_idx_q   <= tx_idx_q + IDX_W'(1);
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_expire) begin
            tx_cnt_q <= CNT_BIT;
            if (tx_pop) begin
              tx_shift_q <= tx_head;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_e         rx_state_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [IDX_W-1:0]  rx_idx_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_expire, rx_stop_hit, rx_push, rx_full, rx_empty;
  logic              ovf_set, frm_set, ovf_q, frm_q;
  logic [ADDR_W-1:0] rx_usage_unused;

  assign rx_s        = sync_q[1];
  assign rx_expire   = (rx_cnt_q == '0);
  assign rx_stop_hit = (rx_state_q == RX_STOP) && rx_expire;
  assign rx_push     = rx_stop_hit && rx_s;
  assign ovf_set     = rx_push && rx_full;
  assign frm_set     = rx_stop_hit && ~rx_s;

  // Two-flop synchroniser for the asynchronous MCU line; resets to idle-high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rx_i};
  end

  // RX deserialiser: half-bit qualify of the start bit, then one sample per bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (~rx_s) begin
            rx_cnt_q   <= CNT_HALF;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_expire) begin
            if (~rx_s) begin
              rx_cnt_q   <= CNT_BIT;
              rx_idx_q   <= '0;
              rx_state_q <= RX_DATA;
            end else begin
              rx_state_q <= RX_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_expire) begin
            rx_cnt_q   <= CNT_BIT;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_W-1:1]};
            if (rx_idx_q == IDX_LAST) rx_state_q <= RX_STOP;
            else                      rx_idx_q   <= rx_idx_q + IDX_W'(1);
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_expire) rx_state_q <= rx_s ? RX_IDLE : RX_WAIT_IDLE;
          else           rx_cnt_q   <= rx_cnt_q - CNT_W'(1);
        end
        RX_WAIT_IDLE: begin
          if (rx_s) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DATA_W),
    .DEPTH        (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_n),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (rx_full),
    .empty_o    (rx_empty),
    .usage_o    (rx_usage_unused),
    .data_i     (rx_shift_q),
    .push_i     (rx_push),
    .data_o     (rx_data_o),
    .pop_i      (rx_ready_i)
  );

  assign rx_valid_o = ~rx_empty;

  // Sticky flags; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      if (ovf_set)          ovf_q <= 1'b1;
      else if (clear_err_i) ovf_q <= 1'b0;
      if (frm_set)          frm_q <= 1'b1;
      else if (clear_err_i) frm_q <= 1'b0;
    end
  end

  assign rx_overflow_o = ovf_q;
  assign frame_err_o   = frm_q;

endmodule

// File: rtl/ps_mcu_uart_bridge.sv
// NUM_CH independent buffered UART channels between the PS and the MCU.
module ps_mcu_uart_bridge
  import ps_mcu_uart_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*DATA_W-1:0] tx_data_i,
  input  logic [NUM_CH-1:0]        tx_valid_i,
  output logic [NUM_CH-1:0]        tx_ready_o,
  output logic [NUM_CH-1:0]        uart_tx_o,
  input  logic [NUM_CH-1:0]        uart_rx_i,
  output logic [NUM_CH*DATA_W-1:0] rx_data_o,
  output logic [NUM_CH-1:0]        rx_valid_o,
  input  logic [NUM_CH-1:0]        rx_ready_i,
  output logic [NUM_CH-1:0]        rx_overflow_o,
  output logic [NUM_CH-1:0]        frame_err_o,
  input  logic [NUM_CH-1:0]        clear_err_i
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ps_mcu_uart_channel #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .BAUD_DIV   (BAUD_DIV)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .tx_data_i     (tx_data_i[c*DATA_W +: DATA_W]),
      .tx_valid_i    (tx_valid_i[c]),
      .tx_ready_o    (tx_ready_o[c]),
      .uart_tx_o     (uart_tx_o[c]),
      .uart_rx_i     (uart_rx_i[c]),
      .rx_data_o     (rx_data_o[c*DATA_W +: DATA_W]),
      .rx_valid_o    (rx_valid_o[c]),
      .rx_ready_i    (rx_ready_i[c]),
      .rx_overflow_o (rx_overflow_o[c]),
      .frame_err_o   (frame_err_o[c]),
      .clear_err_i   (clear_err_i[c])
    );
  end

endmodule

// File: doc/ps_mcu_uart_bridge.md
# ps_mcu_uart_bridge

Parametrised, buffered UART bridge between the Zynq PS fabric side and the X-HEEP MCU UART pins on the biomedical emulation platform. It replaces the single direct PS-UART-to-MCU wire pair with NUM_CH independent channels. Each channel has a TX FIFO and serialiser (PS to MCU) and an RX deserialiser and FIFO (MCU to PS). Each channel also keeps sticky overflow and framing-error flags.

## Interface
Parameters:
- NUM_CH, 2, number of independent UART channels
- DATA_W, 8, data bits per frame (5..9)
- FIFO_DEPTH, 16, entries per TX and per RX FIFO (power of two, ≥2)
- BAUD_DIV, 868, clk_i cycles per bit (≥4; 100 MHz / 115200)

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- tx_data_i  in  NUM_CH*DATA_W  PS write data, channel c in slice [c*DATA_W +: DATA_W]
- tx_valid_i  in  NUM_CH  write request per channel
- tx_ready_o  out  NUM_CH  TX FIFO not full
- uart_tx_o  out  NUM_CH  serial line to MCU uart_rx_i, idle high
- uart_rx_i  in  NUM_CH  serial line from MCU uart_tx_o, asynchronous
- rx_data_o  out  NUM_CH*DATA_W  RX FIFO head (show-ahead)
- rx_valid_o  out  NUM_CH  RX FIFO not empty
- rx_ready_i  in  NUM_CH  pop RX head when valid
- rx_overflow_o  out  NUM_CH  sticky: received byte dropped, RX FIFO full
- frame_err_o  out  NUM_CH  sticky: stop bit sampled low
- clear_err_i  in  NUM_CH  clears both sticky flags of the channel

## Operation
- Channels are fully independent and have identical logic.
- TX FIFO write happens on tx_valid_i & tx_ready_o. tx_ready_o = !full, with no combinational path from the serialiser.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE: if the FIFO is not empty, pop into the shift register and go to TX_START.
  - Each of START/DATA/STOP holds a bit for BAUD_DIV cycles. Data goes out LSB first for DATA_W bits. One stop bit (high).
  - From TX_STOP, go to TX_START directly if the FIFO is not empty (no idle gap), else to TX_IDLE.
- RX: uart_rx_i passes through a 2-flop synchroniser. RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE.
  - RX_IDLE: a low on the synchronised line goes to RX_START with the counter loaded to BAUD_DIV/2 (floor).
  - RX_START: at counter expiry, if the line is still low go to RX_DATA; else treat as a glitch and return to RX_IDLE.
  - RX_DATA: sample DATA_W bits, one every BAUD_DIV cycles, LSB first.
  - RX_STOP: sample after BAUD_DIV cycles.
    - High: push the byte. If the FIFO is full, drop the byte and set rx_overflow_o. Go to RX_IDLE.
    - Low: discard the byte, set frame_err_o, go to RX_WAIT_IDLE.
  - RX_WAIT_IDLE: return to RX_IDLE once the line is sampled high.
- A push into a full RX FIFO is dropped even if a pop occurs in the same cycle.
- Sticky flags: if set and clear_err_i occur in the same cycle, set wins.

## Timing
- Reset values:
  - uart_tx_o = all ones.
  - tx_ready_o = all ones.
  - rx_valid_o, rx_overflow_o and frame_err_o = 0.
  - rx_data_o = 0.
  - Both FSMs idle, all FIFOs empty.
- Reset mid-frame: the line returns high asynchronously and partial frames are lost. No byte is pushed after reset is released.
- TX latency: a byte accepted at edge t into an empty, idle channel drives uart_tx_o low from edge t+2. uart_tx_o is registered.
- TX frame length is (DATA_W+2)*BAUD_DIV cycles. Back-to-back frames have no gap.
- RX latency: rx_valid_o rises 1 cycle after the stop-bit sample edge. The stop bit is sampled about 2 + (DATA_W+1.5)*BAUD_DIV cycles after the line falls, including the synchroniser.
- RX handshake: a pop at edge t updates rx_data_o/rx_valid_o from edge t+1.
- Counter width is $clog2(BAUD_DIV). The bit index width is $clog2(DATA_W+1).

## Structure
- Package ps_mcu_uart_pkg holds tx_state_e, rx_state_e and the width localparams.
- Sub-module ps_mcu_uart_channel contains one channel: TX FIFO, TX FSM, synchroniser, RX FSM, RX FIFO and flags. The top instantiates it NUM_CH times in a generate loop and slices the packed buses.
- FIFOs are common_cells fifo_v3 with FALL_THROUGH=0, DEPTH=FIFO_DEPTH.

## Test plan
All scenarios use NUM_CH=2, DATA_W=8, FIFO_DEPTH=4, BAUD_DIV=4.
1. Write 0xA5 to ch0 at edge t:
   - uart_tx_o[0] goes low at t+2 for 4 cycles, then carries bits 1,0,1,0,0,1,0,1 for 4 cycles each, then is high for 4 cycles.
   - uart_tx_o[1] stays high throughout.
2. Loopback uart_tx_o[1] to uart_rx_i[1] and write 0x00, 0xFF, 0x3C back-to-back (40 cycles per frame, no gaps) with rx_ready_i[1]=1:
   - rx_data_o[1] presents 0x00, 0xFF, 0x3C in order, each with a one-cycle rx_valid_o.
   - No flags are set.
3. Write 6 bytes to ch0 on consecutive cycles:
   - tx_ready_o[0] drops once 4 entries are queued (1 byte is in the shifter).
   - It reasserts 1 cycle after the next pop.
   - All bytes are serialised in order.
4. With rx_ready_i[0]=0, send 5 frames into ch0:
   - 4 bytes are stored, rx_valid_o[0]=1.
   - The 5th is dropped and rx_overflow_o[0]=1.
   - clear_err_i[0] pulse clears the flag.
   - Popping 4 times returns the first 4 bytes.
5. Send a ch1 frame with stop bit 0, hold the line low 20 cycles, then idle and send 0x55:
   - The first frame gives no push and frame_err_o[1]=1.
   - 0x55 is received correctly afterwards.
6. Assert rst_i in the middle of a ch0 TX data bit and a ch1 RX frame:
   - uart_tx_o goes high asynchronously.
   - After release, all outputs are at reset values and no byte appears on rx_valid_o.
